// File: rtl/ctrl_bank_masked_pkg.sv
// ctrl_bank_masked_pkg
//   Shared definitions for the control-register bank: the bus halfword width
//   and the state encoding of the two-halfword command assembler.
package ctrl_bank_masked_pkg;

  // Width of one bus halfword (data word and mask word are each one halfword).
  localparam int HW = 16;

  // Command assembler states: waiting for a data halfword, waiting for the
  // mask halfword, and the cycle in which the assembled word is committed.
  typedef enum logic [1:0] {
    ASM_IDLE   = 2'd0,
    ASM_MASK   = 2'd1,
    ASM_COMMIT = 2'd2
  } asm_state_t;

endpackage

// File: rtl/ctrl_bank_masked_asm.sv
// ctrl_word_asm
//   Assembles a two-halfword write command (data, then per-bit mask) from the
//   sclk-domain bus and presents it for one commit cycle.
// Ports
//   sclk   in   1   system clock, all flops on its falling edge
//   rst_n  in   1   asynchronous active-low reset; drops any partial command
//   wen    in   1   write strobe (already qualified by reset release)
//   wa     in   AW  register address, sampled with wen
//   di     in   HW  data halfword with wen, mask halfword in the next cycle
//   addr   out  AW  latched register address
//   dat    out  HW  latched data halfword
//   msk    out  HW  latched mask halfword
//   commit out  1   assembled word is valid this cycle (address in range)
//   err    out  1   one-cycle error event: wen during the mask cycle, or bad address
module ctrl_word_asm
  import ctrl_bank_masked_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic [AW-1:0] wa,
  input  logic [HW-1:0] di,
  output logic [AW-1:0] addr,
  output logic [HW-1:0] dat,
  output logic [HW-1:0] msk,
  output logic          commit,
  output logic          err
);

  asm_state_t state, state_nxt;
  logic       take_word;
  logic       wa_bad;
  logic       addr_bad;

  assign wa_bad = (int'(wa) >= NREG);

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ASM_IDLE;
      addr     <= '0;
      dat      <= '0;
      msk      <= '0;
      addr_bad <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_word) begin
        addr     <= wa;
        dat      <= di;
        addr_bad <= wa_bad;
      end
      // The halfword following the data is always the mask, even when a
      // stray wen arrives with it.
      if (state == ASM_MASK) begin
        msk <= di;
      end
    end
  end

  // A new command may start in the commit cycle, which is what allows writes
  // every second cycle. A word with an out-of-range address is still walked
  // through the states but never raises commit.
  always_comb begin
    state_nxt = state;
    take_word = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;
    case (state)
      ASM_IDLE: begin
        if (wen) begin
          take_word = 1'b1;
          state_nxt = ASM_MASK;
        end
      end
      ASM_MASK: begin
        state_nxt = ASM_COMMIT;
        if (wen) begin
          err = 1'b1;
        end
      end
      ASM_COMMIT: begin
        commit = !addr_bad;
        if (wen) begin
          take_word = 1'b1;
          state_nxt = ASM_MASK;
        end else begin
          state_nxt = ASM_IDLE;
        end
      end
      default: state_nxt = ASM_IDLE;
    endcase
    if (take_word && wa_bad) begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_bank_masked.sv
// ctrl_bank_masked
//   Bank of NREG control registers written by masked two-halfword commands.
//   Registers flagged in DEFER_MASK collect writes in a shadow copy and copy it
//   to the active value on frame_sync. Bits flagged in PULSE_MASK self-clear
//   one cycle after they become visible. Read-back is registered.
// Ports
//   sclk       in   1        system clock, all flops on its falling edge
//   rst_n      in   1        asynchronous active-low reset
//   wen        in   1        write strobe, qualifies wa and the data halfword
//   wa         in   AW       register address
//   di         in   16       data halfword, then mask halfword
//   frame_sync in   1        applies pending deferred registers
//   ra         in   AW       read-back address
//   rsel       in   1        0: read active value, 1: read shadow
//   q          out  NREG*DW  active register values, reg i at [i*DW +: DW]
//   pend       out  NREG     shadow of reg i holds an unapplied write
//   rd         out  DW       registered read-back data
//   wr_err     out  1        sticky write error, cleared only by reset
module ctrl_bank_masked
  import ctrl_bank_masked_pkg::*;
#(
  parameter int                 NREG       = 4,
  parameter int                 AW         = 2,
  parameter int                 DW         = 16,
  parameter logic [NREG*DW-1:0] RST_VAL    = '0,
  parameter logic [NREG-1:0]    DEFER_MASK = '0,
  parameter logic [NREG*DW-1:0] PULSE_MASK = '0
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               wen,
  input  logic [AW-1:0]      wa,
  input  logic [HW-1:0]      di,
  input  logic               frame_sync,
  input  logic [AW-1:0]      ra,
  input  logic               rsel,
  output logic [NREG*DW-1:0] q,
  output logic [NREG-1:0]    pend,
  output logic [DW-1:0]      rd,
  output logic               wr_err
);

  // Pulse bits never come out of reset set.
  localparam logic [NREG*DW-1:0] RST_EFF = RST_VAL & ~PULSE_MASK;

  logic          ready;
  logic [AW-1:0] c_addr;
  logic [HW-1:0] c_dat;
  logic [HW-1:0] c_msk;
  logic          c_commit;
  logic          c_err;
  logic          unused_hw_bits;

  logic [DW-1:0] q_r    [NREG];
  logic [DW-1:0] sh_r   [NREG];
  logic [DW-1:0] q_nxt  [NREG];
  logic [DW-1:0] sh_nxt [NREG];
  logic [NREG-1:0] pend_r, pend_nxt;
  logic [DW-1:0] rd_nxt;
  logic [DW-1:0] clr, bq, bs, mv;
  logic          hit;

  // Reset release is taken through a flop so that the first accepted wen is
  // the one sampled on the second falling edge after rst_n rises.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end

  ctrl_word_asm #(
    .NREG (NREG),
    .AW   (AW)
  ) u_asm (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .wen    (wen & ready),
    .wa     (wa),
    .di     (di),
    .addr   (c_addr),
    .dat    (c_dat),
    .msk    (c_msk),
    .commit (c_commit),
    .err    (c_err)
  );

  assign unused_hw_bits = ^{c_dat, c_msk};

  // Pulse bits that are visible now are cleared from both copies before any
  // merge, so a commit on the same edge can set them again. For deferred
  // registers the merge goes into the shadow first; frame_sync then copies the
  // merged shadow, which is how a coinciding commit lands in the same edge.
  always_comb begin
    q_nxt    = q_r;
    sh_nxt   = sh_r;
    pend_nxt = pend_r;
    clr      = '0;
    bq       = '0;
    bs       = '0;
    mv       = '0;
    hit      = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      clr = q_r[i] & PULSE_MASK[i*DW +: DW];
      bq  = q_r[i] & ~clr;
      bs  = sh_r[i] & ~clr;
      hit = c_commit && (c_addr == AW'(i));
      if (DEFER_MASK[i]) begin
        mv        = hit ? ((bs & ~c_msk[DW-1:0]) | (c_dat[DW-1:0] & c_msk[DW-1:0])) : bs;
        sh_nxt[i] = mv;
        q_nxt[i]  = bq;
        if (frame_sync && (pend_r[i] || hit)) begin
          q_nxt[i]    = mv;
          pend_nxt[i] = 1'b0;
        end else if (hit) begin
          pend_nxt[i] = 1'b1;
        end
      end else begin
        mv          = hit ? ((bq & ~c_msk[DW-1:0]) | (c_dat[DW-1:0] & c_msk[DW-1:0])) : bq;
        q_nxt[i]    = mv;
        sh_nxt[i]   = mv;
        pend_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    if (int'(ra) < NREG) begin
      rd_nxt = rsel ? sh_r[ra] : q_r[ra];
    end
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        q_r[i]  <= RST_EFF[i*DW +: DW];
        sh_r[i] <= RST_EFF[i*DW +: DW];
      end
      pend_r <= '0;
      rd     <= '0;
      wr_err <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      sh_r   <= sh_nxt;
      pend_r <= pend_nxt;
      rd     <= rd_nxt;
      wr_err <= wr_err | c_err;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_q
    assign q[g*DW +: DW] = q_r[g];
  end

  assign pend = pend_r;

endmodule

// File: tb/tb_ctrl_bank_masked.sv
// tb_ctrl_bank_masked
//   Directed bench for ctrl_bank_masked with NREG=4, DW=16, reg1 reset to
//   00F0, reg2 deferred, bit 0 of reg0 a pulse bit. Read-back expectations go
//   through a queue: pushed in the cycle the read address is driven, popped
//   one edge later when rd carries the result.
module tb_ctrl_bank_masked;

  localparam int NREG = 4;
  localparam int AW   = 2;
  localparam int DW   = 16;
  localparam logic [63:0] RST_VAL    = 64'h0000_0000_00F0_0000;
  localparam logic [3:0]  DEFER_MASK = 4'b0100;
  localparam logic [63:0] PULSE_MASK = 64'h0000_0000_0000_0001;

  logic          sclk;
  logic          rst_n;
  logic          wen;
  logic [AW-1:0] wa;
  logic [15:0]   di;
  logic          frame_sync;
  logic [AW-1:0] ra;
  logic          rsel;
  logic [63:0]   q;
  logic [3:0]    pend;
  logic [15:0]   rd;
  logic          wr_err;

  typedef struct {
    logic        chk;
    logic [15:0] val;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      n_vec;
  int      n_bad;

  ctrl_bank_masked #(
    .NREG       (NREG),
    .AW         (AW),
    .DW         (DW),
    .RST_VAL    (RST_VAL),
    .DEFER_MASK (DEFER_MASK),
    .PULSE_MASK (PULSE_MASK)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .wen        (wen),
    .wa         (wa),
    .di         (di),
    .frame_sync (frame_sync),
    .ra         (ra),
    .rsel       (rsel),
    .q          (q),
    .pend       (pend),
    .rd         (rd),
    .wr_err     (wr_err)
  );

  initial begin
    sclk = 1'b1;
    forever #5 sclk = ~sclk;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts one cycle: compares rd against the expectation queued by the
  // previous cycle, drives this cycle's inputs, and queues the value rd must
  // show after this cycle's closing edge.
  task automatic apply_stimulus(input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                                input logic fs, input logic [AW-1:0] r, input logic rs,
                                input logic ck, input logic [15:0] er);
    rd_exp_t e;
    @(negedge sclk);
    #1;
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      if (e.chk) check_output("rd", {48'h0, rd}, {48'h0, e.val});
    end
    wen        = w;
    wa         = a;
    di         = d;
    frame_sync = fs;
    ra         = r;
    rsel       = rs;
    e.chk      = ck;
    e.val      = er;
    rd_q.push_back(e);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, 16'h0000, 1'b0, '0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic idle_di(input logic [15:0] d);
    apply_stimulus(1'b0, '0, d, 1'b0, '0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    rd_q.delete();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    wen = 1'b0; wa = '0; di = '0; frame_sync = 1'b0; ra = '0; rsel = 1'b0;

    // Reset state.
    idle();
    idle();
    check_output("rst_q", q, 64'h0000_0000_00F0_0000);
    check_output("rst_pend", {60'h0, pend}, 64'h0);
    check_output("rst_wr_err", {63'h0, wr_err}, 64'h0);
    check_output("rst_rd", {48'h0, rd}, 64'h0);
    idle();
    rst_n = 1'b1;
    idle();

    // Immediate masked write to reg1.
    apply_stimulus(1'b1, 2'd1, 16'h00A5, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'h000F);
    idle();
    check_output("imm_before_commit", q, 64'h0000_0000_00F0_0000);
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd1, 1'b0, 1'b1, 16'h00F5);
    check_output("imm_q1", q, 64'h0000_0000_00F5_0000);
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd1, 1'b1, 1'b1, 16'h00F5);
    idle();
    check_output("imm_wr_err", {63'h0, wr_err}, 64'h0);

    // Deferred reg2: two back-to-back writes accumulate in the shadow.
    apply_stimulus(1'b1, 2'd2, 16'h1234, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'hFFFF);
    apply_stimulus(1'b1, 2'd2, 16'h0000, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'h00FF);
    idle();
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd2, 1'b1, 1'b1, 16'h1200);
    check_output("def_pend", {60'h0, pend}, 64'h4);
    check_output("def_q_unchanged", q, 64'h0000_0000_00F5_0000);
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd2, 1'b0, 1'b1, 16'h0000);
    apply_stimulus(1'b0, '0, 16'h0, 1'b1, 2'd2, 1'b1, 1'b1, 16'h1200);
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd2, 1'b0, 1'b1, 16'h1200);
    check_output("fs_q2", q, 64'h0000_1200_00F5_0000);
    check_output("fs_pend", {60'h0, pend}, 64'h0);
    idle();

    // Commit to reg2 on the same edge as frame_sync.
    apply_stimulus(1'b1, 2'd2, 16'hABCD, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'h0F0F);
    apply_stimulus(1'b0, '0, 16'h0, 1'b1, '0, 1'b0, 1'b0, 16'h0);
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd2, 1'b0, 1'b1, 16'h1B0D);
    check_output("fs_commit_q2", q, 64'h0000_1B0D_00F5_0000);
    check_output("fs_commit_pend", {60'h0, pend}, 64'h0);
    idle();

    // Pulse bit 0 of reg0.
    apply_stimulus(1'b1, 2'd0, 16'h0001, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'h0001);
    idle();
    check_output("pulse_before", {48'h0, q[15:0]}, 64'h0);
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0001);
    check_output("pulse_high", {48'h0, q[15:0]}, 64'h1);
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b1, 16'h0000);
    check_output("pulse_cleared", {48'h0, q[15:0]}, 64'h0);
    idle();

    // Mask of zero produces no pulse.
    apply_stimulus(1'b1, 2'd0, 16'h0001, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'h0000);
    idle();
    idle();
    check_output("pulse_mask0", {48'h0, q[15:0]}, 64'h0);

    // Second wen in the mask cycle: error, no extra commit.
    apply_stimulus(1'b1, 2'd3, 16'h00AA, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    apply_stimulus(1'b1, 2'd3, 16'h00FF, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'hFFFF);
    idle_di(16'hFFFF);
    check_output("maskwen_q3", q, 64'h00AA_1B0D_00F5_0000);
    check_output("maskwen_err", {63'h0, wr_err}, 64'h1);
    idle_di(16'hFFFF);
    check_output("maskwen_no_extra", q, 64'h00AA_1B0D_00F5_0000);
    idle();

    // Reset during the mask cycle of a write to reg3.
    apply_stimulus(1'b1, 2'd3, 16'h5555, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'hFFFF);
    enter_reset();
    idle();
    check_output("midrst_q", q, 64'h0000_0000_00F0_0000);
    check_output("midrst_pend", {60'h0, pend}, 64'h0);
    check_output("midrst_wr_err", {63'h0, wr_err}, 64'h0);
    check_output("midrst_rd", {48'h0, rd}, 64'h0);

    // wen sampled on the first edge after release is ignored.
    apply_stimulus(1'b1, 2'd3, 16'h1111, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b1;
    idle_di(16'hFFFF);
    idle_di(16'hFFFF);
    idle_di(16'hFFFF);
    check_output("early_wen_ignored", q, 64'h0000_0000_00F0_0000);
    idle();

    // wen sampled on the second edge after release is accepted.
    enter_reset();
    idle();
    idle();
    rst_n = 1'b1;
    apply_stimulus(1'b1, 2'd3, 16'h2222, 1'b0, '0, 1'b0, 1'b0, 16'h0);
    idle_di(16'hFFFF);
    idle();
    apply_stimulus(1'b0, '0, 16'h0, 1'b0, 2'd3, 1'b0, 1'b1, 16'h2222);
    check_output("second_edge_wen", q, 64'h2222_0000_00F0_0000);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
